// File: rtl/t_ff_counter_ctrl_if.sv
// t_ff_counter_ctrl_if: control and status bundle between the sequencer, its controller and the T-FF bank
interface t_ff_counter_ctrl_if #(parameter int WIDTH = 4);
  logic start, stop, oneshot, up;
  logic [WIDTH-1:0] t_out, q;
  logic tc, busy, done;
  modport master(output start, stop, oneshot, up, input t_out, q, tc, busy, done);
  modport slave(input start, stop, oneshot, up, output t_out, q, tc, busy, done);
endinterface

// File: rtl/t_ff_counter_ctrl.sv
// t_ff_counter_ctrl: toggle-vector sequencer driving a WIDTH-bit T-FF bank as a mod-MODULUS up/down counter
module t_ff_counter_ctrl #(
  parameter int WIDTH = 4,
  parameter int MODULUS = 10
) (
  input logic clk,
  input logic clr,
  t_ff_counter_ctrl_if.slave bus
);
  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
    $fatal(1, "t_ff_counter_ctrl: MODULUS out of range");
  end
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
  logic [1:0] state, state_nx;
  logic [WIDTH-1:0] q, nxt, init, t_out;
  logic dir_r, os_r, go, tc;
  // wrap is explicit so MODULUS below 2**WIDTH never relies on overflow
  assign nxt = dir_r ? (q == MAX ? '0 : q + 1'b1) : (q == '0 ? MAX : q - 1'b1);
  assign init = bus.up ? '0 : MAX;
  assign go = state == S_IDLE && !bus.stop && bus.start;
  assign tc = state == S_RUN && (dir_r ? q == MAX : q == '0);
  always_comb begin
    t_out = go ? q ^ init : (state == S_RUN && !bus.stop) ? q ^ nxt : '0;
    state_nx = state == S_IDLE ? (go ? S_RUN : S_IDLE)
             : state == S_RUN ? (bus.stop ? S_IDLE : (tc && os_r ? S_DONE : S_RUN))
             : S_IDLE;
  end
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= S_IDLE;
      q <= '0;
      dir_r <= 1'b1;
      os_r <= 1'b0;
    end else begin
      state <= state_nx;
      q <= q ^ t_out;
      if (go) begin
        dir_r <= bus.up;
        os_r <= bus.oneshot;
      end
    end
  end
  assign bus.t_out = t_out;
  assign bus.q = q;
  assign bus.tc = tc;
  assign bus.busy = state == S_RUN;
  assign bus.done = state == S_DONE;
endmodule

// File: tb/tb_t_ff_counter_ctrl.sv
// tb_t_ff_counter_ctrl: directed checks of the T-FF counter sequencer at MODULUS 10 and 16
module tb_t_ff_counter_ctrl;
  logic clk, clr;
  int checks, errors;
  t_ff_counter_ctrl_if #(.WIDTH(4)) b0();
  t_ff_counter_ctrl_if #(.WIDTH(4)) b1();
  t_ff_counter_ctrl #(.WIDTH(4), .MODULUS(10)) u0 (.clk(clk), .clr(clr), .bus(b0.slave));
  t_ff_counter_ctrl #(.WIDTH(4), .MODULUS(16)) u1 (.clk(clk), .clr(clr), .bus(b1.slave));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // status packed as {q, t_out, tc, busy, done}
  function automatic logic [10:0] st0();
    return {b0.q, b0.t_out, b0.tc, b0.busy, b0.done};
  endfunction
  function automatic logic [10:0] st1();
    return {b1.q, b1.t_out, b1.tc, b1.busy, b1.done};
  endfunction
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic test_reset();
    clr = 1'b0;
    {b0.start, b0.stop, b0.oneshot, b0.up} = 4'b0;
    {b1.start, b1.stop, b1.oneshot, b1.up} = 4'b0;
    #3;
    checks++;
    if (st0() !== 11'h0) begin
      errors++;
      $display("FAIL reset0 got %h exp %h", st0(), 11'h0);
    end
    checks++;
    if (st1() !== 11'h0) begin
      errors++;
      $display("FAIL reset1 got %h exp %h", st1(), 11'h0);
    end
    step();
    step();
    clr = 1'b1;
    step();
    checks++;
    if (st0() !== 11'h0) begin
      errors++;
      $display("FAIL reset_release got %h exp %h", st0(), 11'h0);
    end
  endtask
  task automatic test_up_free();
    logic [3:0] eq, en;
    b0.start = 1'b1;
    b0.up = 1'b1;
    b0.oneshot = 1'b0;
    #1;
    checks++;
    if (st0() !== 11'h0) begin
      errors++;
      $display("FAIL up_start got %h exp %h", st0(), 11'h0);
    end
    step();
    b0.start = 1'b0;
    for (int i = 0; i < 25; i++) begin
      eq = 4'(i % 10);
      en = (eq == 4'd9) ? 4'd0 : eq + 4'd1;
      checks++;
      if (st0() !== {eq, eq ^ en, eq == 4'd9, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL up_run i=%0d got %h exp %h", i, st0(), {eq, eq ^ en, eq == 4'd9, 1'b1, 1'b0});
      end
      step();
    end
    checks++;
    if (b0.q !== 4'd5) begin
      errors++;
      $display("FAIL up_wrap_end got %0d exp 5", b0.q);
    end
  endtask
  task automatic test_stop();
    b0.stop = 1'b1;
    #1;
    checks++;
    if (st0() !== {4'd5, 4'd0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL stop_cycle got %h exp %h", st0(), {4'd5, 4'd0, 1'b0, 1'b1, 1'b0});
    end
    step();
    b0.stop = 1'b0;
    #1;
    checks++;
    if (st0() !== {4'd5, 4'd0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL stop_idle got %h exp %h", st0(), {4'd5, 4'd0, 1'b0, 1'b0, 1'b0});
    end
    b0.start = 1'b1;
    b0.up = 1'b1;
    #1;
    checks++;
    if (b0.t_out !== 4'd5) begin
      errors++;
      $display("FAIL restart_tout got %h exp %h", b0.t_out, 4'd5);
    end
    step();
    b0.start = 1'b0;
    checks++;
    if (st0() !== {4'd0, 4'd1, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL restart_q got %h exp %h", st0(), {4'd0, 4'd1, 1'b0, 1'b1, 1'b0});
    end
    b0.stop = 1'b1;
    step();
    b0.stop = 1'b0;
  endtask
  task automatic test_start_stop();
    b0.start = 1'b1;
    b0.stop = 1'b1;
    #1;
    checks++;
    if (st0() !== 11'h0) begin
      errors++;
      $display("FAIL ss_idle_tout got %h exp %h", st0(), 11'h0);
    end
    step();
    checks++;
    if (st0() !== 11'h0) begin
      errors++;
      $display("FAIL ss_idle_hold got %h exp %h", st0(), 11'h0);
    end
    b0.stop = 1'b0;
    step();
    b0.start = 1'b0;
    step();
    b0.start = 1'b1;
    b0.stop = 1'b1;
    #1;
    checks++;
    if (st0() !== {4'd1, 4'd0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL ss_run_tout got %h exp %h", st0(), {4'd1, 4'd0, 1'b0, 1'b1, 1'b0});
    end
    step();
    b0.start = 1'b0;
    b0.stop = 1'b0;
    #1;
    checks++;
    if (st0() !== {4'd1, 4'd0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL ss_run_idle got %h exp %h", st0(), {4'd1, 4'd0, 1'b0, 1'b0, 1'b0});
    end
  endtask
  task automatic test_oneshot_down();
    logic [3:0] eq, en;
    b0.start = 1'b1;
    b0.up = 1'b0;
    b0.oneshot = 1'b1;
    #1;
    checks++;
    if (b0.t_out !== 4'd8) begin
      errors++;
      $display("FAIL os_start_tout got %h exp %h", b0.t_out, 4'd8);
    end
    step();
    b0.start = 1'b0;
    b0.up = 1'b1;
    b0.oneshot = 1'b0;
    for (int k = 0; k < 10; k++) begin
      eq = 4'(9 - k);
      en = (eq == 4'd0) ? 4'd9 : eq - 4'd1;
      checks++;
      if (st0() !== {eq, eq ^ en, eq == 4'd0, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL os_run k=%0d got %h exp %h", k, st0(), {eq, eq ^ en, eq == 4'd0, 1'b1, 1'b0});
      end
      step();
    end
    b0.start = 1'b1;
    b0.stop = 1'b1;
    #1;
    checks++;
    if (st0() !== {4'd9, 4'd0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL os_done got %h exp %h", st0(), {4'd9, 4'd0, 1'b0, 1'b0, 1'b1});
    end
    step();
    b0.start = 1'b0;
    b0.stop = 1'b0;
    #1;
    checks++;
    if (st0() !== {4'd9, 4'd0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL os_after got %h exp %h", st0(), {4'd9, 4'd0, 1'b0, 1'b0, 1'b0});
    end
    step();
    checks++;
    if (st0() !== {4'd9, 4'd0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL os_hold got %h exp %h", st0(), {4'd9, 4'd0, 1'b0, 1'b0, 1'b0});
    end
  endtask
  task automatic test_async_reset();
    b0.start = 1'b1;
    b0.up = 1'b1;
    b0.oneshot = 1'b1;
    step();
    b0.start = 1'b0;
    for (int i = 0; i < 7; i++) step();
    checks++;
    if (b0.q !== 4'd7) begin
      errors++;
      $display("FAIL ar_pre got %0d exp 7", b0.q);
    end
    #2;
    clr = 1'b0;
    #1;
    checks++;
    if (st0() !== 11'h0) begin
      errors++;
      $display("FAIL ar_immediate got %h exp %h", st0(), 11'h0);
    end
    step();
    clr = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      checks++;
      if (st0() !== 11'h0) begin
        errors++;
        $display("FAIL ar_after i=%0d got %h exp %h", i, st0(), 11'h0);
      end
    end
  endtask
  task automatic test_full_width();
    b1.start = 1'b1;
    b1.up = 1'b1;
    step();
    b1.start = 1'b0;
    for (int i = 0; i < 15; i++) step();
    checks++;
    if (st1() !== {4'hf, 4'hf, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL fw_up_wrap got %h exp %h", st1(), {4'hf, 4'hf, 1'b1, 1'b1, 1'b0});
    end
    step();
    checks++;
    if (st1() !== {4'h0, 4'h1, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL fw_up_zero got %h exp %h", st1(), {4'h0, 4'h1, 1'b0, 1'b1, 1'b0});
    end
    b1.stop = 1'b1;
    step();
    b1.stop = 1'b0;
    b1.start = 1'b1;
    b1.up = 1'b0;
    #1;
    checks++;
    if (b1.t_out !== 4'hf) begin
      errors++;
      $display("FAIL fw_dn_start got %h exp %h", b1.t_out, 4'hf);
    end
    step();
    b1.start = 1'b0;
    checks++;
    if (st1() !== {4'hf, 4'h1, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL fw_dn_init got %h exp %h", st1(), {4'hf, 4'h1, 1'b0, 1'b1, 1'b0});
    end
    for (int i = 0; i < 15; i++) step();
    checks++;
    if (st1() !== {4'h0, 4'hf, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL fw_dn_wrap got %h exp %h", st1(), {4'h0, 4'hf, 1'b1, 1'b1, 1'b0});
    end
    step();
    checks++;
    if (b1.q !== 4'hf) begin
      errors++;
      $display("FAIL fw_dn_fifteen got %h exp %h", b1.q, 4'hf);
    end
    b1.stop = 1'b1;
    step();
    b1.stop = 1'b0;
  endtask
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_up_free();
    test_stop();
    test_start_stop();
    test_oneshot_down();
    test_async_reset();
    test_full_width();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/t_ff_counter_ctrl.md
Name: t_ff_counter_ctrl

Overview:
- Sequencer for a bank of WIDTH T flip-flops used as a mod-MODULUS up/down counter.
- Each cycle it computes the per-bit toggle vector that moves the bank to its next count.
- It mirrors the bank state internally and provides run/stop control, a one-shot mode and terminal-count/done status.
- It sits between control logic and the T-FF bank; t_out drives the T inputs directly, and clk and clr are shared with the bank.

Parameters:
WIDTH, 4, counter/T-FF bank width in bits.
MODULUS, 10, count modulus. Legal range 2 <= MODULUS <= 2**WIDTH. Count range is 0..MODULUS-1.

Ports:
clk  input  1  rising-edge clock, shared with the T-FF bank.
clr  input  1  asynchronous active-low reset/clear. Asserting it (0) clears all state immediately, independent of clk.
start  input  1  begin counting. Sampled in IDLE only.
stop  input  1  abort counting. Has priority over all other inputs.
oneshot  input  1  1 = stop after one full modulus period. Sampled together with start.
up  input  1  direction, 1 = up, 0 = down. Sampled together with start.
t_out  output  WIDTH  toggle vector to the T-FF bank. Combinational from state and q.
q  output  WIDTH  mirrored count, equal to the bank contents.
tc  output  1  terminal count (combinational).
busy  output  1  high while in RUN.
done  output  1  one-cycle pulse on one-shot completion.

Behaviour:
- Reset (clr=0, asynchronous):
  - state=IDLE, q=0, dir_r=1, os_r=0.
  - t_out=0, tc=0, busy=0, done=0.
  - Reset applied mid-RUN aborts immediately, with no done pulse.
  - Reset release is synchronous to the next clk edge.
- Registered state: FSM state (IDLE, RUN, DONE), q[WIDTH], dir_r, os_r.
- q update every edge: q <= q XOR t_out. The bank itself is never read back.
- next(q):
  - dir_r=1: 0 if q==MODULUS-1, else q+1.
  - dir_r=0: MODULUS-1 if q==0, else q-1.
  - Arithmetic is WIDTH bits; the wrap is explicit, never by natural overflow (MODULUS may be less than 2**WIDTH).
- init value: 0 when up=1, MODULUS-1 when up=0.
- IDLE:
  - busy=0, tc=0.
  - If stop=1: t_out=0, stay in IDLE (stop beats a simultaneous start).
  - Else if start=1: t_out = q XOR init; dir_r<=up; os_r<=oneshot; go to RUN. After the edge, q = init.
  - Else: t_out=0.
- RUN:
  - busy=1. tc = (dir_r ? q==MODULUS-1 : q==0).
  - If stop=1: t_out=0, q holds, go to IDLE.
  - Else t_out = q XOR next(q). The first advance occurs on the edge after the start edge.
  - If tc=1 and os_r=1: the wrap still happens (q goes to init), then go to DONE.
  - start in RUN is ignored; up and oneshot changes are ignored until the next start.
- DONE:
  - done=1, busy=0, t_out=0, q holds.
  - Unconditionally go to IDLE next cycle. start and stop are ignored in this cycle.
- Timing of done: it asserts exactly MODULUS cycles after the start edge and lasts 1 cycle.
- Free run (os_r=0): wraps indefinitely. tc pulses 1 cycle every MODULUS cycles.
- Invariant: q < MODULUS at all times. t_out is all-zero outside the start cycle and RUN.
- Illegal MODULUS values are caught by an elaboration-time check (fatal).

Test Plan:
1. Reset then free-run up, WIDTH=4, MODULUS=10.
   - clr low, then high; start=1, up=1, oneshot=0 for one cycle.
   - q sequence 0,1,…,9,0,1…; tc high exactly when q=9.
   - t_out = 0001 at q=0→1, 0011 at q=1→2, 1001 at q=9→0.
   - busy stays 1.
2. One-shot down, MODULUS=10.
   - start with up=0, oneshot=1.
   - q = 9,8,…,0,9; tc at q=0.
   - done=1 for 1 cycle exactly 10 cycles after the start edge; then busy=0 and q=9 holds.
3. Stop mid-run.
   - Run up, assert stop at q=5.
   - t_out=0 that cycle; q holds 5; state IDLE next cycle.
   - A re-start reloads q to 0.
4. Simultaneous start and stop.
   - In IDLE: no transition, t_out=0, q unchanged.
   - In RUN: stop taken, start ignored.
5. Asynchronous reset mid-run.
   - Drop clr between edges at q=7.
   - q=0, busy=0, t_out=0 immediately with no clock edge; done never pulses.
6. Full-width modulus, MODULUS=16.
   - Free-run up: wrap 15→0 with t_out=1111.
   - Down run: 0→15 with t_out=1111.
   - tc asserts at 15 and at 0 respectively.
